mux2_arbiter: RTL and testbench



---
 rtl/mux_ctrl_pkg.sv | 13 +
 rtl/mux2_w.sv | 11 +
 rtl/mux2_arbiter.sv | 87 ++++++++
 tb/tb_mux2_arbiter.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_pkg.sv
// mux_ctrl_pkg: state encoding and sizing helper for the 2:1 mux arbiter
package mux_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/mux2_w.sv
// mux2_w: WIDTH+1-bit 2:1 mux carrying data plus last flag
module mux2_w #(
  parameter int W = 9
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

// File: rtl/mux2_arbiter.sv
// mux2_arbiter: round-robin packet arbiter driving a shared 2:1 valid/ready mux
module mux2_arbiter
  import mux_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_last,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_last,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel,
  output logic             busy
);
  localparam int CW  = clog2(MAX_BEATS > 1 ? MAX_BEATS : 2);
  localparam int LIM = (MAX_BEATS > 0) ? MAX_BEATS - 1 : (1 << CW) - 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(LIM);

  logic [1:0]    state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH:0] mux_y;
  logic          cur_valid, oth_valid, xfer, at_lim, rel;

  mux2_w #(.W(WIDTH + 1)) u_mux (
    .sel_i (sel),
    .a_i   ({in0_last, in0_data}),
    .b_i   ({in1_last, in1_data}),
    .y_o   (mux_y)
  );

  assign cur_valid = sel ? in1_valid : in0_valid;
  assign oth_valid = sel ? in0_valid : in1_valid;
  assign xfer      = out_valid & out_ready;
  assign at_lim    = (MAX_BEATS != 0) && (cnt_q == CNT_MAX);
  assign rel       = xfer & (out_last | (at_lim & oth_valid));

  // state, grant history and beat counter; async reset forces an immediate release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
    end
  end

  // arbitration from IDLE, release and direct handover while granted
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (!busy)
      state_d = (in0_valid & in1_valid) ? (last_grant_q ? G0 : G1) :
                in0_valid ? G0 : in1_valid ? G1 : IDLE;
    else if (rel) begin
      last_grant_d = sel;
      state_d      = oth_valid ? (sel ? G0 : G1) :
                     (cur_valid & ~out_last) ? (sel ? G1 : G0) : IDLE;
    end
    cnt_d = (rel || state_d != state_q) ? '0 :
            (xfer && cnt_q != CNT_MAX) ? cnt_q + CW'(1) : cnt_q;
  end

  // datapath passes through combinationally; only the granted side sees ready
  always_comb begin
    busy      = (state_q == G0) || (state_q == G1);
    sel       = (state_q == G1);
    out_valid = busy & cur_valid;
    out_data  = mux_y[WIDTH-1:0];
    out_last  = busy & mux_y[WIDTH];
    in0_ready = (state_q == G0) & out_ready;
    in1_ready = (state_q == G1) & out_ready;
  end
endmodule

// File: tb/tb_mux2_arbiter.sv
// tb_mux2_arbiter: table-driven and stream checks for mux2_arbiter
module tb_mux2_arbiter;
  logic       clk = 0;
  logic       rst_n = 0;
  logic       in0_valid = 0, in0_last = 0, in0_ready;
  logic [7:0] in0_data = 0;
  logic       in1_valid = 0, in1_last = 0, in1_ready;
  logic [7:0] in1_data = 0;
  logic       out_valid, out_last, out_ready = 0, sel, busy;
  logic [7:0] out_data;

  int checks = 0;
  int errors = 0;
  int idx = 0;

  typedef struct {
    logic r, v0, l0, v1, l1, rdy;
    logic [7:0] d0, d1;
    logic ov, ol, r0, r1, sl, bz;
    logic [7:0] od;
  } vec_t;
  vec_t vecs[$];

  mux2_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1, input logic rdy,
                     input logic ov, input logic [7:0] od, input logic ol,
                     input logic r0, r1, sl, bz);
    vec_t v;
    v.r = r; v.v0 = v0; v.d0 = d0; v.l0 = l0; v.v1 = v1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
    v.ov = ov; v.od = od; v.ol = ol; v.r0 = r0; v.r1 = r1; v.sl = sl; v.bz = bz;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h want %0h", name, idx, act, exp);
    end
  endtask

  task automatic run_stream(input bit with1);
    logic [7:0] exp[$];
    int p0, p1, k, first, lastc;
    exp = {};
    for (int i = 0; i < 4; i++) exp.push_back(8'h50 + 8'(i));
    if (with1) begin
      exp.push_back(8'h61);
      exp.push_back(8'h62);
    end
    for (int i = 4; i < 10; i++) exp.push_back(8'h50 + 8'(i));
    rst_n = 0; in0_valid = 0; in1_valid = 0; in0_last = 0; in1_last = 0; out_ready = 0;
    @(negedge clk);
    rst_n = 1;
    p0 = 0; p1 = 0; k = 0; first = -1; lastc = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      idx = 1000 + cyc;
      in0_valid = (p0 < 10);
      in0_data  = 8'h50 + 8'(p0);
      in0_last  = (p0 == 9);
      in1_valid = with1 && cyc >= 2 && p1 < 2;
      in1_data  = 8'h61 + 8'(p1);
      in1_last  = (p1 == 1);
      out_ready = 1;
      #1;
      if (out_valid) begin
        if (k < exp.size()) begin
          chk("stream_data", 32'(out_data), 32'(exp[k]));
          chk("stream_sel", 32'(sel), 32'(exp[k][7:4] == 4'h6));
        end else
          chk("stream_extra_beat", 32'(k), 32'(exp.size() - 1));
        if (first < 0) first = cyc;
        lastc = cyc;
        k++;
      end
      if (in0_valid && in0_ready) p0++;
      if (in1_valid && in1_ready) p1++;
      @(negedge clk);
    end
    chk("stream_count", 32'(k), 32'(exp.size()));
    chk("stream_contiguous", 32'(lastc - first + 1), 32'(exp.size()));
    chk("stream_first_latency", 32'(first), 32'd1);
  endtask

  initial begin
    // reset mid-packet in G1, then requester 0 gets sel=0 one cycle after valid
    add(0, 0,8'h00,0, 0,8'h00,0, 0,  0,8'h00,0, 0,0,0,0);
    add(1, 0,8'h00,0, 1,8'h71,0, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 0,8'h00,0, 1,8'h72,0, 1,  1,8'h72,0, 0,1,1,1);
    add(0, 1,8'h05,1, 1,8'h73,1, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h05,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h06,0, 0,8'h00,0, 1,  1,8'h06,0, 1,0,0,1);
    // both valid from IDLE, back-to-back 3-beat packets
    add(0, 0,8'h00,0, 0,8'h00,0, 0,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h11,0, 1,8'h21,0, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h11,0, 1,8'h21,0, 1,  1,8'h11,0, 1,0,0,1);
    add(1, 1,8'h12,0, 1,8'h21,0, 1,  1,8'h12,0, 1,0,0,1);
    add(1, 1,8'h13,1, 1,8'h21,0, 1,  1,8'h13,1, 1,0,0,1);
    add(1, 0,8'h00,0, 1,8'h21,0, 1,  1,8'h21,0, 0,1,1,1);
    add(1, 0,8'h00,0, 1,8'h22,0, 1,  1,8'h22,0, 0,1,1,1);
    add(1, 0,8'h00,0, 1,8'h23,1, 1,  1,8'h23,1, 0,1,1,1);
    add(1, 0,8'h00,0, 0,8'h00,0, 1,  0,8'h00,0, 0,0,0,0);
    // out_ready 1,0,0,1,1,1 in G0: counter frozen while low, limit hit on 4th transfer
    add(0, 0,8'h00,0, 0,8'h00,0, 0,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h31,0, 1,8'h41,0, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'h31,0, 1,8'h41,0, 1,  1,8'h31,0, 1,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,0, 0,  1,8'h31,0, 0,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,0, 0,  1,8'h31,0, 0,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,0, 1,  1,8'h31,0, 1,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,0, 1,  1,8'h31,0, 1,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,0, 1,  1,8'h31,0, 1,0,0,1);
    add(1, 1,8'h31,0, 1,8'h41,1, 1,  1,8'h41,1, 0,1,1,1);
    add(1, 1,8'h31,0, 0,8'h41,0, 1,  1,8'h31,0, 1,0,0,1);
    // single-beat packets from both sides alternate every cycle
    add(0, 0,8'h00,0, 0,8'h00,0, 0,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'hA0,1, 1,8'hB0,1, 1,  0,8'h00,0, 0,0,0,0);
    add(1, 1,8'hA0,1, 1,8'hB0,1, 1,  1,8'hA0,1, 1,0,0,1);
    add(1, 1,8'hA0,1, 1,8'hB0,1, 1,  1,8'hB0,1, 0,1,1,1);
    add(1, 1,8'hA0,1, 1,8'hB0,1, 1,  1,8'hA0,1, 1,0,0,1);
    add(1, 1,8'hA0,1, 1,8'hB0,1, 1,  1,8'hB0,1, 0,1,1,1);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      idx = i;
      rst_n = vecs[i].r;
      in0_valid = vecs[i].v0; in0_data = vecs[i].d0; in0_last = vecs[i].l0;
      in1_valid = vecs[i].v1; in1_data = vecs[i].d1; in1_last = vecs[i].l1;
      out_ready = vecs[i].rdy;
      #1;
      chk("out_valid", 32'(out_valid), 32'(vecs[i].ov));
      chk("out_last",  32'(out_last),  32'(vecs[i].ol));
      chk("in0_ready", 32'(in0_ready), 32'(vecs[i].r0));
      chk("in1_ready", 32'(in1_ready), 32'(vecs[i].r1));
      chk("sel",       32'(sel),       32'(vecs[i].sl));
      chk("busy",      32'(busy),      32'(vecs[i].bz));
      if (vecs[i].ov) chk("out_data", 32'(out_data), 32'(vecs[i].od));
      @(negedge clk);
    end

    run_stream(1'b0);
    run_stream(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
